// File: rtl/dcc_bit_encoder_n.sv
// DCC bit encoder: turns a valid/ready bit stream into the track waveform
// (low half then high half per bit), with fill-'1' on underrun, zero-stretch and a RailCom cutout.
module dcc_bit_encoder_n #(
  parameter int HALF_W     = 8,
  parameter int ONE_HALF   = 58,
  parameter int ZERO_HALF  = 100,
  parameter int CUTOUT_LEN = 464,
  parameter int CUT_W      = 10
) (
  input  logic              dcc_clk,
  input  logic              reset_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  input  logic [HALF_W-1:0] stretch,
  input  logic              cutout_req,
  output logic              encoded_out,
  output logic              out_en,
  output logic              in_cutout,
  output logic              underrun
);

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_HIGH   = 2'd1,
    ST_CUTOUT = 2'd2
  } state_t;

  localparam logic [HALF_W:0]  ONE_LAST  = (HALF_W+1)'(ONE_HALF - 1);
  localparam logic [HALF_W:0]  ZERO_LAST = (HALF_W+1)'(ZERO_HALF - 1);
  localparam logic [HALF_W:0]  CNT_INC   = {{HALF_W{1'b0}}, 1'b1};
  localparam logic [CUT_W-1:0] CUT_LAST  = CUT_W'(CUTOUT_LEN - 1);
  localparam logic [CUT_W-1:0] CUT_INC   = {{(CUT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic              cur_bit_q, cur_bit_d;
  logic [HALF_W:0]   cnt_q, cnt_d;
  logic [CUT_W-1:0]  cut_cnt_q, cut_cnt_d;
  logic [HALF_W-1:0] str_q, str_d;
  logic              enc_q, enc_d;
  logic              out_en_q, out_en_d;
  logic              in_cutout_q, in_cutout_d;
  logic              underrun_q, underrun_d;
  logic              bit_ready_s;
  logic              low_last_s, high_last_s, cut_last_s;

  // Last-cycle detection for each phase; the stretch only lengthens the high half of a '0'.
  always_comb begin
    low_last_s  = (cnt_q == (cur_bit_q ? ONE_LAST : ZERO_LAST));
    high_last_s = cur_bit_q ? (cnt_q == ONE_LAST)
                            : (cnt_q == (ZERO_LAST + {1'b0, str_q}));
    cut_last_s  = (cut_cnt_q == CUT_LAST);
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    cur_bit_d   = cur_bit_q;
    cnt_d       = cnt_q;
    cut_cnt_d   = cut_cnt_q;
    str_d       = str_q;
    enc_d       = enc_q;
    out_en_d    = out_en_q;
    in_cutout_d = in_cutout_q;
    underrun_d  = 1'b0;
    bit_ready_s = 1'b0;
    case (state_q)
      ST_LOW: begin
        // out_en is only low in LOW straight after reset: that first edge just enables the bridge.
        if (!out_en_q) begin
          out_en_d = 1'b1;
          cnt_d    = '0;
        end else if (low_last_s) begin
          enc_d   = 1'b1;
          state_d = ST_HIGH;
          cnt_d   = '0;
          str_d   = stretch;
        end else begin
          cnt_d = cnt_q + CNT_INC;
        end
      end
      ST_HIGH: begin
        if (high_last_s) begin
          cnt_d = '0;
          enc_d = 1'b0;
          if (cutout_req) begin
            out_en_d    = 1'b0;
            in_cutout_d = 1'b1;
            cut_cnt_d   = '0;
            state_d     = ST_CUTOUT;
          end else begin
            bit_ready_s = 1'b1;
            state_d     = ST_LOW;
            if (bit_valid) begin
              cur_bit_d = bit_in;
            end else begin
              cur_bit_d  = 1'b1;
              underrun_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_INC;
        end
      end
      ST_CUTOUT: begin
        if (cut_last_s) begin
          bit_ready_s = 1'b1;
          out_en_d    = 1'b1;
          in_cutout_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_LOW;
          if (bit_valid) begin
            cur_bit_d = bit_in;
          end else begin
            cur_bit_d  = 1'b1;
            underrun_d = 1'b1;
          end
        end else begin
          cut_cnt_d = cut_cnt_q + CUT_INC;
        end
      end
      default: begin
        state_d     = ST_LOW;
        cur_bit_d   = 1'b1;
        cnt_d       = '0;
        enc_d       = 1'b0;
        out_en_d    = 1'b0;
        in_cutout_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge dcc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_LOW;
      cur_bit_q   <= 1'b1;
      cnt_q       <= '0;
      cut_cnt_q   <= '0;
      str_q       <= '0;
      enc_q       <= 1'b0;
      out_en_q    <= 1'b0;
      in_cutout_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_bit_q   <= cur_bit_d;
      cnt_q       <= cnt_d;
      cut_cnt_q   <= cut_cnt_d;
      str_q       <= str_d;
      enc_q       <= enc_d;
      out_en_q    <= out_en_d;
      in_cutout_q <= in_cutout_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bit_ready   = bit_ready_s;
  assign encoded_out = enc_q;
  assign out_en      = out_en_q;
  assign in_cutout   = in_cutout_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_dcc_bit_encoder_n.sv
// Directed self-checking bench for dcc_bit_encoder_n: idle fill, back-to-back bits,
// stretch, cutout, underrun and mid-bit reset, with hand-computed cycle expectations.
module tb_dcc_bit_encoder_n;

  localparam int HALF_W     = 4;
  localparam int ONE_HALF   = 2;
  localparam int ZERO_HALF  = 4;
  localparam int CUTOUT_LEN = 10;
  localparam int CUT_W      = 4;

  logic              dcc_clk;
  logic              reset_n;
  logic              bit_in;
  logic              bit_valid;
  logic              bit_ready;
  logic [HALF_W-1:0] stretch;
  logic              cutout_req;
  logic              encoded_out;
  logic              out_en;
  logic              in_cutout;
  logic              underrun;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic enc_t [0:63];
  logic oe_t  [0:63];
  logic ic_t  [0:63];
  logic ur_t  [0:63];
  logic rdy_t [0:63];
  int   hi_runs[$];
  int   lo_runs[$];
  int   xfers[$];
  int   s2_bits[3] = '{1, 0, 1};
  int   idx;

  dcc_bit_encoder_n #(
    .HALF_W    (HALF_W),
    .ONE_HALF  (ONE_HALF),
    .ZERO_HALF (ZERO_HALF),
    .CUTOUT_LEN(CUTOUT_LEN),
    .CUT_W     (CUT_W)
  ) dut (
    .dcc_clk    (dcc_clk),
    .reset_n    (reset_n),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .stretch    (stretch),
    .cutout_req (cutout_req),
    .encoded_out(encoded_out),
    .out_en     (out_en),
    .in_cutout  (in_cutout),
    .underrun   (underrun)
  );

  initial begin
    dcc_clk = 1'b0;
    forever #5 dcc_clk = ~dcc_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One rising edge, then park on the falling edge for sampling/driving.
  task automatic step();
    @(posedge dcc_clk);
    @(negedge dcc_clk);
  endtask

  task automatic rec(input int k);
    enc_t[k] = encoded_out;
    oe_t[k]  = out_en;
    ic_t[k]  = in_cutout;
    ur_t[k]  = underrun;
    rdy_t[k] = bit_ready;
  endtask

  task automatic apply_reset(input string pfx);
    reset_n = 1'b0;
    #1;
    check({pfx, "_rst_enc"}, encoded_out, 0);
    check({pfx, "_rst_oe"},  out_en,      0);
    check({pfx, "_rst_rdy"}, bit_ready,   0);
    check({pfx, "_rst_ic"},  in_cutout,   0);
    check({pfx, "_rst_ur"},  underrun,    0);
    repeat (2) @(negedge dcc_clk);
    check({pfx, "_hold_oe"},  out_en,    0);
    check({pfx, "_hold_rdy"}, bit_ready, 0);
    reset_n = 1'b1;
  endtask

  function automatic int count_sel(input int sel, input int a, input int b);
    int c;
    c = 0;
    for (int k = a; k <= b; k++) begin
      case (sel)
        0:       c += int'(enc_t[k]);
        1:       c += int'(oe_t[k]);
        2:       c += int'(ic_t[k]);
        3:       c += int'(ur_t[k]);
        4:       c += int'(rdy_t[k]);
        default: c += 0;
      endcase
    end
    return c;
  endfunction

  // Completed high/low run lengths of encoded_out over samples 1..n (leading low run skipped).
  task automatic calc_runs(input int n);
    int start;
    bit seen;
    hi_runs.delete();
    lo_runs.delete();
    start = 1;
    seen  = 1'b0;
    for (int k = 2; k <= n; k++) begin
      if (enc_t[k] !== enc_t[k-1]) begin
        if (enc_t[k-1] === 1'b1) begin
          hi_runs.push_back(k - start);
          seen = 1'b1;
        end else if (seen) begin
          lo_runs.push_back(k - start);
        end
        start = k;
      end
    end
  endtask

  // Idle stream of fill '1's: period 4, underrun each boundary except the reset bit.
  task automatic idle_check(input string pfx);
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("%s_oe%0d", pfx, k),  out_en,      1);
      check($sformatf("%s_enc%0d", pfx, k), encoded_out, ((k - 1) / 2) % 2);
      check($sformatf("%s_ur%0d", pfx, k),  underrun,    (k >= 5 && k % 4 == 1) ? 1 : 0);
      check($sformatf("%s_rdy%0d", pfx, k), bit_ready,   (k % 4 == 0) ? 1 : 0);
    end
  endtask

  initial begin
    reset_n    = 1'b1;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    stretch    = '0;
    cutout_req = 1'b0;
    #2;

    // Idle after reset
    apply_reset("s1");
    idle_check("s1");

    // Back-to-back 1,0,1
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    apply_reset("s2");
    idx = 0;
    xfers.delete();
    for (int k = 1; k <= 24; k++) begin
      step();
      if (idx < 3) begin
        bit_valid = 1'b1;
        bit_in    = s2_bits[idx][0];
      end else begin
        bit_valid = 1'b0;
        bit_in    = 1'b0;
      end
      rec(k);
      if (bit_ready && bit_valid) begin
        xfers.push_back(k + 1);
        idx++;
      end
    end
    check("s2_nxfer", xfers.size(), 3);
    check("s2_xfer0", xfers[0], 5);
    check("s2_xfer1", xfers[1], 9);
    check("s2_xfer2", xfers[2], 17);
    check("s2_ur21",  ur_t[21], 1);
    check("s2_nur",   count_sel(3, 1, 24), 1);
    calc_runs(24);
    check("s2_nhi", hi_runs.size(), 4);
    check("s2_hi0", hi_runs[0], 2);
    check("s2_hi1", hi_runs[1], 2);
    check("s2_hi2", hi_runs[2], 4);
    check("s2_hi3", hi_runs[3], 2);
    check("s2_nlo", lo_runs.size(), 4);
    check("s2_lo0", lo_runs[0], 2);
    check("s2_lo1", lo_runs[1], 4);
    check("s2_lo2", lo_runs[2], 2);
    check("s2_lo3", lo_runs[3], 2);

    // Zero stretch, changed mid high half
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    stretch   = 4'd3;
    apply_reset("s3");
    for (int k = 1; k <= 36; k++) begin
      step();
      if (k == 11) stretch = 4'd9;
      rec(k);
    end
    calc_runs(36);
    check("s3_nhi", hi_runs.size(), 3);
    check("s3_hi0", hi_runs[0], 2);
    check("s3_hi1", hi_runs[1], 7);
    check("s3_hi2", hi_runs[2], 13);
    check("s3_nlo", lo_runs.size(), 2);
    check("s3_lo0", lo_runs[0], 4);
    check("s3_lo1", lo_runs[1], 4);
    check("s3_nur", count_sel(3, 1, 36), 0);
    stretch = '0;

    // Cutout requested during the reset '1'
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    apply_reset("s4");
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 3) cutout_req = 1'b1;
      else if (k == 5) cutout_req = 1'b0;
      rec(k);
    end
    check("s4_rdy4",  rdy_t[4], 0);
    check("s4_oe4",   oe_t[4],  1);
    check("s4_oe5",   oe_t[5],  0);
    check("s4_ic5",   ic_t[5],  1);
    check("s4_oe14",  oe_t[14], 0);
    check("s4_ic14",  ic_t[14], 1);
    check("s4_rdy14", rdy_t[14], 1);
    check("s4_oe15",  oe_t[15], 1);
    check("s4_ic15",  ic_t[15], 0);
    check("s4_nlowoe", 20 - count_sel(1, 1, 20), 10);
    check("s4_nic",   count_sel(2, 1, 20), 10);
    check("s4_nrdy",  count_sel(4, 1, 20), 1);
    check("s4_encct", count_sel(0, 5, 14), 0);
    check("s4_enc18", enc_t[18], 0);
    check("s4_enc19", enc_t[19], 1);
    check("s4_nur",   count_sel(3, 1, 20), 0);

    // One missed boundary, then the held '0'
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    apply_reset("s5");
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 4) bit_valid = 1'b0;
      else if (k == 5) bit_valid = 1'b1;
      rec(k);
    end
    check("s5_ur5", ur_t[5], 1);
    check("s5_nur", count_sel(3, 1, 15), 1);
    calc_runs(15);
    check("s5_nhi", hi_runs.size(), 2);
    check("s5_hi0", hi_runs[0], 2);
    check("s5_hi1", hi_runs[1], 2);
    check("s5_nlo", lo_runs.size(), 2);
    check("s5_lo0", lo_runs[0], 2);
    check("s5_lo1", lo_runs[1], 4);
    check("s5_midhi", encoded_out, 1);

    // Reset in the middle of the '0' high half, then idle restart
    bit_valid = 1'b0;
    apply_reset("s6");
    idle_check("s6");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
